mux_stream_n: RTL
=================

# mux_stream_n

Parametrised N-channel, WIDTH-bit registered stream multiplexer for the ALU datapath; the successor to the combinational 4:1 8-bit selector. Each input channel has its own valid/ready handshake. The block selects one channel per cycle, either by an explicit select (fixed mode) or by a round-robin scan (arbitrated mode), and presents the winner on a registered output with a valid/ready handshake and a channel tag. It sits between the operand sources and the ALU input stage.

## Interface
- WIDTH, 8: data width per channel, 1..32.
- CHANNELS, 4: number of input channels, 2..16.
- SEL_W, $clog2(CHANNELS): select/tag width (derived; do not override).

- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- mode_i  in  1  0 = fixed select via s_i, 1 = round-robin.
- s_i  in  SEL_W  channel select, used when mode_i = 0.
- data_i  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- valid_i  in  CHANNELS  per-channel data valid.
- ready_o  out  CHANNELS  per-channel accept; at most one bit high.
- c_o  out  WIDTH  registered selected data.
- chan_o  out  SEL_W  index of the channel that produced c_o.
- valid_o  out  1  c_o/chan_o hold a word.
- ready_i  in  1  downstream accept.

## Operation
- load_en = !valid_o || ready_i. The output register may load only when load_en is high.
- Fixed mode: the candidate is channel s_i. A grant exists when s_i < CHANNELS and valid_i[s_i] = 1. If s_i >= CHANNELS (non-power-of-2 CHANNELS), there is no grant and no ready_o bit is asserted.
- Round-robin mode: the candidate is the first k with valid_i[k] = 1, scanning ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1.
  - ptr is a SEL_W-bit register.
  - On each accepted transfer in this mode, ptr <= (k+1) mod CHANNELS. Wrap goes from CHANNELS-1 to 0.
  - ptr is unchanged in fixed mode and on cycles with no transfer.
- ready_o[k] = load_en && grant && (candidate == k). It is combinational from valid_i, mode_i, s_i, ptr, valid_o and ready_i. ready_o must not depend on data_i.
- On a clock edge with load_en high:
  - with a grant: c_o <= data_i[k], chan_o <= k, valid_o <= 1;
  - without a grant: valid_o <= 0, and c_o/chan_o hold.
- With load_en low, c_o, chan_o and valid_o hold. No input is accepted, so no data is dropped.
- A word presented on c_o stays stable until the cycle in which valid_o && ready_i.
- A mode_i or s_i change takes effect combinationally in the same cycle. It never corrupts a word already in the output register.

## Timing
- Reset (rst_ni low, asynchronous): c_o = 0, chan_o = 0, valid_o = 0, ptr = 0. ready_o is all zero while rst_ni is low.
- Latency: an input accepted at edge n is on c_o with valid_o = 1 after edge n.
- Throughput: one word per cycle while ready_i = 1 and a grant exists.
- Simultaneous pop and push: if valid_o = 1, ready_i = 1 and a grant exists, the old word leaves and the new word loads on the same edge with no bubble.
- Backpressure: valid_o = 1 with ready_i = 0 holds everything, and ready_o = 0 on all channels.
- Reset mid-stream: the output word is discarded, ptr returns to 0, and the first grant after release follows the reset rules.
- Fairness: in round-robin mode with all channels continuously valid and ready_i = 1, the grant sequence is 0,1,...,CHANNELS-1,0,... Each channel is served once per CHANNELS cycles.

## Test plan
- Reset: hold rst_ni = 0 with all valid_i = 1 -> c_o = 0, chan_o = 0, valid_o = 0, ready_o = 0; the first round-robin grant after release is channel 0.
- Fixed mode, CHANNELS = 4, WIDTH = 8:
  - stimulus: s_i = 2, data_i lanes = 0x11/0x22/0x33/0x44, all valid, ready_i = 1;
  - response: ready_o = 4'b0100; next cycle c_o = 0x33, chan_o = 2, valid_o = 1; one word per cycle thereafter.
- Round-robin wrap:
  - stimulus: mode_i = 1, valid_i = 4'b1001, ready_i = 1;
  - response: grants 0,3,0,3,...; after the channel-3 grant, ptr = 0.
- Backpressure:
  - stimulus: hold ready_i = 0 for 3 cycles after a word with c_o = 0xA5 is loaded;
  - response: c_o stays 0xA5, valid_o stays 1, ready_o = 0 throughout; releasing ready_i accepts the next word on that edge with no bubble.
- Empty/no grant: all valid_i = 0, ready_i = 1 -> valid_o falls the next cycle and c_o holds its last value.
- Non-power-of-2, CHANNELS = 3:
  - stimulus: fixed mode, s_i = 3;
  - response: ready_o = 0, valid_o = 0.
  - In round-robin mode with all valid, grants are 0,1,2,0.

Source files
------------

// File: rtl/mux_stream_n.sv
// N-channel registered stream multiplexer: fixed-select or round-robin choice of one
// valid/ready input channel per cycle, presented on a registered, tagged output.
module mux_stream_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mode_i,
  input  logic [SEL_W-1:0]          s_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [CHANNELS-1:0]       valid_i,
  output logic [CHANNELS-1:0]       ready_o,
  output logic [WIDTH-1:0]          c_o,
  output logic [SEL_W-1:0]          chan_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  logic [WIDTH-1:0] c_q, c_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic             load_en;
  logic             grant;
  logic [SEL_W-1:0] cand;
  logic [WIDTH-1:0] cand_data;

  // Channel visited at scan offset off when starting from pointer p (p < CHANNELS).
  function automatic int rr_idx(input int p, input int off);
    int sum;
    sum = p + off;
    return (sum >= CHANNELS) ? sum - CHANNELS : sum;
  endfunction

  assign load_en = !valid_q || ready_i;

  // Candidate selection depends only on handshake/control inputs, never on data_i.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path infers a latch.
    grant = 1'b0;
    cand  = '0;
    if (mode_i) begin
      // Scan backwards so the lowest offset from ptr is the last (winning) assignment.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (valid_i[rr_idx(int'(ptr_q), i)]) begin
          grant = 1'b1;
          cand  = SEL_W'(rr_idx(int'(ptr_q), i));
        end
      end
    end else begin
      // An out-of-range select matches no channel and therefore never grants.
      for (int k = 0; k < CHANNELS; k++) begin
        if (int'(s_i) == k) begin
          grant = valid_i[k];
          cand  = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    cand_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(cand) == k) cand_data = data_i[k*WIDTH +: WIDTH];
    end
  end

  // Handshake is held off during reset even though the output register reads empty.
  always_comb begin
    ready_o = '0;
    if (rst_ni && load_en && grant) begin
      for (int k = 0; k < CHANNELS; k++) begin
        ready_o[k] = (int'(cand) == k);
      end
    end
  end

  always_comb begin
    c_d     = c_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (grant) begin
        c_d     = cand_data;
        chan_d  = cand;
        valid_d = 1'b1;
        if (mode_i) begin
          ptr_d = (int'(cand) == CHANNELS - 1) ? '0 : SEL_W'(int'(cand) + 1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q     <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking so all registers update together from pre-edge values.
      c_q     <= c_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign c_o     = c_q;
  assign chan_o  = chan_q;
  assign valid_o = valid_q;

endmodule
